// File: rtl/reg_bank_param_if.sv
// Request/acknowledge register bus between the AXI4-Lite slave and its register banks.
// Several banks may hang off one bus; their response lines are OR-combined upstream.
interface reg_bank_param_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
);
    logic                  axi_wreq;
    logic [ADDR_W-1:0]     axi_waddr;
    logic [DATA_W-1:0]     axi_wdata;
    logic [DATA_W/8-1:0]   axi_wstrb;
    logic                  axi_wack;
    logic                  axi_werr;
    logic                  axi_rreq;
    logic [ADDR_W-1:0]     axi_raddr;
    logic [DATA_W-1:0]     axi_rdata;
    logic                  axi_rack;
    logic                  axi_rerr;

    modport master (
        output axi_wreq, axi_waddr, axi_wdata, axi_wstrb, axi_rreq, axi_raddr,
        input  axi_wack, axi_werr, axi_rdata, axi_rack, axi_rerr
    );

    modport slave (
        input  axi_wreq, axi_waddr, axi_wdata, axi_wstrb, axi_rreq, axi_raddr,
        output axi_wack, axi_werr, axi_rdata, axi_rack, axi_rerr
    );
endinterface

// File: rtl/reg_bank_param.sv
// Parametrised register bank with byte strobes, RW/RO/W1C registers, error reporting,
// per-register write strobes and a registered interrupt from the W1C registers.
module reg_bank_param #(
    parameter int unsigned                DATA_W       = 32,
    parameter int unsigned                ADDR_W       = 14,
    parameter int unsigned                BASE_W       = 7,
    parameter logic [BASE_W-1:0]          BASE_ADDRESS = '0,
    parameter int unsigned                NUM_REGS     = 16,
    parameter logic [NUM_REGS-1:0]        RO_MASK      = '0,
    parameter logic [NUM_REGS-1:0]        W1C_MASK     = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL    = '0
) (
    input  logic                         AXI_ACLK,
    input  logic                         axi_rstn,
    reg_bank_param_if.slave              bus,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    output logic [NUM_REGS-1:0]          reg_wr_pulse,
    output logic                         irq
);
    localparam int unsigned IDX_W = ADDR_W - BASE_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic              whit, rhit;
    logic [IDX_W-1:0]  widx, ridx;
    logic [DATA_W-1:0] wmask;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] cur    [NUM_REGS];

    logic [NUM_REGS-1:0] pulse_d, pulse_q;
    logic                wack_d, wack_q, werr_d, werr_q;
    logic                rack_d, rack_q, rerr_d, rerr_q;
    logic [DATA_W-1:0]   rdata_d, rdata_q;
    logic                irq_d, irq_q;

    assign whit = (bus.axi_waddr[ADDR_W-1 -: BASE_W] == BASE_ADDRESS);
    assign rhit = (bus.axi_raddr[ADDR_W-1 -: BASE_W] == BASE_ADDRESS);
    assign widx = bus.axi_waddr[IDX_W-1:0];
    assign ridx = bus.axi_raddr[IDX_W-1:0];

    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++) begin
            wmask[b*8 +: 8] = {8{bus.axi_wstrb[b]}};
        end
    end

    // RO registers expose the live hardware status instead of stored state.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cur[i] = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : regs_q[i];
            reg_q[i*DATA_W +: DATA_W] = cur[i];
        end
    end

    always_comb begin
        logic wsel;
        logic w_ok, w_ro, r_ok, w1c_any;
        wsel    = 1'b0;
        w_ok    = 1'b0;
        w_ro    = 1'b0;
        r_ok    = 1'b0;
        w1c_any = 1'b0;
        rdata_d = '0;
        pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wsel      = bus.axi_wreq && whit && (widx == IDX_W'(i));
            regs_d[i] = regs_q[i];
            if (W1C_MASK[i]) begin
                if (wsel) regs_d[i] = regs_q[i] & ~(bus.axi_wdata & wmask);
                // Hardware set wins over a software clear of the same bit.
                regs_d[i] = regs_d[i] | hw_set[i*DATA_W +: DATA_W];
                w1c_any   = w1c_any | (|regs_q[i]);
            end else if (!RO_MASK[i]) begin
                if (wsel) regs_d[i] = (regs_q[i] & ~wmask) | (bus.axi_wdata & wmask);
            end
            if (wsel) begin
                w_ok       = 1'b1;
                w_ro       = RO_MASK[i];
                pulse_d[i] = !RO_MASK[i];
            end
            if (bus.axi_rreq && rhit && (ridx == IDX_W'(i))) begin
                r_ok    = 1'b1;
                rdata_d = cur[i];
            end
        end
        wack_d = bus.axi_wreq && whit;
        werr_d = wack_d && (!w_ok || w_ro);
        rack_d = bus.axi_rreq && rhit;
        rerr_d = rack_d && !r_ok;
        irq_d  = w1c_any;
    end

    always_ff @(posedge AXI_ACLK or negedge axi_rstn) begin
        if (!axi_rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
            pulse_q <= '0;
            wack_q  <= 1'b0;
            werr_q  <= 1'b0;
            rack_q  <= 1'b0;
            rerr_q  <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pulse_q <= pulse_d;
            wack_q  <= wack_d;
            werr_q  <= werr_d;
            rack_q  <= rack_d;
            rerr_q  <= rerr_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.axi_wack  = wack_q;
    assign bus.axi_werr  = werr_q;
    assign bus.axi_rack  = rack_q;
    assign bus.axi_rerr  = rerr_q;
    assign bus.axi_rdata = rdata_q;
    assign reg_wr_pulse  = pulse_q;
    assign irq           = irq_q;
endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
- Parametrised register bank for the AXI4-Lite slave's req/ack register bus, replacing fixed 4-register sub-peripherals.
- Sits behind the AXI4-Lite slave. Several instances share one bus at different BASE_ADDRESS values; their responses are OR-combined upstream.
- Adds configurable register count, byte strobes, and per-register access modes (RW, RO, W1C).
- Adds decode/access error reporting, per-register write strobes and an interrupt output.

Parameters:
DATA_W, 32, register and bus data width (multiple of 8)
ADDR_W, 14, bus word-address width
BASE_W, 7, upper address bits compared against BASE_ADDRESS
BASE_ADDRESS, 7'h00, bank select value matched on addr[ADDR_W-1 -: BASE_W]
NUM_REGS, 16, implemented registers, 1..2**(ADDR_W-BASE_W)
RO_MASK, {NUM_REGS{1'b0}}, bit i=1: register i is read-only (reads hw_status)
W1C_MASK, {NUM_REGS{1'b0}}, bit i=1: register i is write-1-to-clear, hardware-set
RESET_VAL, {NUM_REGS*DATA_W{1'b0}}, reset value of register i at slice i

Ports:
AXI_ACLK  in  1  clock
axi_rstn  in  1  reset, asynchronous, active-low
axi_wreq  in  1  write request, one-cycle pulse
axi_waddr  in  ADDR_W  write word address
axi_wdata  in  DATA_W  write data
axi_wstrb  in  DATA_W/8  byte enables
axi_wack  out  1  write acknowledge
axi_werr  out  1  write error, valid with axi_wack
axi_rreq  in  1  read request, one-cycle pulse
axi_raddr  in  ADDR_W  read word address
axi_rdata  out  DATA_W  read data, valid with axi_rack, else 0
axi_rack  out  1  read acknowledge
axi_rerr  out  1  read error, valid with axi_rack
reg_q  out  NUM_REGS*DATA_W  current register contents (RO slices = hw_status)
hw_status  in  NUM_REGS*DATA_W  live values for RO registers
hw_set  in  NUM_REGS*DATA_W  per-bit set for W1C registers
reg_wr_pulse  out  NUM_REGS  one-cycle strobe per successfully written register
irq  out  1  OR of all W1C register bits

Behaviour:
- Reset (axi_rstn low, asynchronous):
  - registers load RESET_VAL;
  - axi_wack, axi_werr, axi_rack, axi_rerr, reg_wr_pulse and irq go to 0; axi_rdata goes to 0.
- Decode:
  - hit = (addr[ADDR_W-1 -: BASE_W] == BASE_ADDRESS); idx = addr[ADDR_W-BASE_W-1:0].
  - No hit: no ack, no error, axi_rdata stays 0, no state change.
- Write, request in cycle N with hit:
  - idx >= NUM_REGS: no update; wack=1, werr=1 at N+1.
  - RO register: no update; wack=1, werr=1 at N+1.
  - RW register: each byte b with wstrb[b]=1 takes wdata byte b at the N→N+1 edge.
  - W1C register: bits in enabled bytes where wdata=1 clear.
  - RW or W1C: wack=1, werr=0 and reg_wr_pulse[idx]=1 at N+1.
  - wstrb=0 still acks with werr=0 and still pulses reg_wr_pulse.
- Read, request in cycle N with hit:
  - rack=1 at N+1, with rdata = register value sampled in cycle N (RO: hw_status sampled in N); rerr=0.
  - idx >= NUM_REGS: rack=1, rerr=1, rdata=0.
- Response lines are single-cycle pulses. Back-to-back requests every cycle are legal; each is acked one cycle later.
- A read and a write in the same cycle are serviced independently. If both target the same register, the read returns the pre-write value.
- W1C registers:
  - hw_set bits OR into the register every cycle.
  - Set has priority over a software clear of the same bit in the same cycle.
  - hw_set on RW/RO registers is ignored.
- irq is registered: irq at N+1 = OR of all W1C register bits in cycle N.
- Reset asserted mid-transaction: pending ack is dropped and no response is issued after reset release.

Test Plan:
- Common config: BASE_ADDRESS=7'h11, NUM_REGS=4, RO_MASK=4'b0100, W1C_MASK=4'b1000.
- Write 32'hdeadbeef to waddr 14'h0880, wstrb 4'hF; then read 14'h0880 -> wack=1, werr=0, reg_wr_pulse=4'b0001 one cycle after; rack with rdata=32'hdeadbeef, rerr=0.
- Write 32'h11223344 to 14'h0881 with wstrb 4'b0101 over reset value 0 -> register 1 reads 32'h00220044.
- hw_status[2]=32'hcafef00d; write 32'h0 to 14'h0882 -> werr=1; read 14'h0882 -> rdata=32'hcafef00d, rerr=0.
- W1C register 3:
  - pulse hw_set[3] = 32'h0000_0005 -> irq=1; read returns 32'h5;
  - write 32'h1 -> reads 32'h4, irq=1;
  - write 32'h4 in the same cycle as hw_set bit 2 -> bit 2 stays 1.
- Read 14'h0884 (idx 4 >= NUM_REGS) -> rack=1, rerr=1, rdata=0.
- Read 14'h0000 (other bank) -> no rack, rdata=0.
- Reset mid-operation: assert axi_rstn low in the cycle after a wreq -> no wack seen; all registers equal RESET_VAL after release.
